vga_frame_decoder: RTL

- Receive-side counterpart of the VGA output path: samples hsync/vsync/RGB from the display pipeline and recovers pixel coordinates.
- Verifies 640x480@60 timing and locks onto the frame.
- Reports the per-frame bounding box of "red" (ball-coloured) pixels.
- Used as an in-fabric monitor and self-check for the pong display, and to track ball position for scoring logic.

---
 rtl/vga_frame_decoder.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_frame_decoder.sv
// Receive-side VGA monitor: checks line/frame timing, locks to the frame and reports the red-pixel bounding box.
// Define VGA_FRAME_DECODER_PIXCOUNT_EN to add obj_count (red visible pixels in the last published frame).
module vga_frame_decoder #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter logic        SYNC_ACTIVE = 1'b0,
  parameter int unsigned PIX_DELAY   = 1,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [3:0]  r_in,
  input  logic [3:0]  g_in,
  input  logic [3:0]  b_in,
  output logic        locked,
  output logic        frame_done,
  output logic        obj_found,
  output logic [9:0]  obj_xmin,
  output logic [9:0]  obj_xmax,
  output logic [9:0]  obj_ymin,
  output logic [9:0]  obj_ymax
`ifdef VGA_FRAME_DECODER_PIXCOUNT_EN
  ,
  output logic [18:0] obj_count
`endif
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned X0      = H_SYNC + H_BACK + PIX_DELAY;
  localparam int unsigned Y0      = V_SYNC + V_BACK;
  localparam int unsigned CNT_MAX = 1023;
  localparam int unsigned LW      = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;

  typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED} state_t;

  // input staging
  logic          hs_q, vs_q;
  logic [3:0]    r_q, g_q, b_q;
  logic          hs_act_d;

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      hs_q     <= ~SYNC_ACTIVE;
      vs_q     <= ~SYNC_ACTIVE;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      hs_act_d <= 1'b0;
    end else begin
      hs_q     <= hs_in;
      vs_q     <= vs_in;
      r_q      <= r_in;
      g_q      <= g_in;
      b_q      <= b_in;
      hs_act_d <= (hs_q == SYNC_ACTIVE);
    end
  end

  logic          hs_act_c, vs_act_c, hs_edge_c;
  logic [CW-1:0] h_run, hcnt_c, vcnt;
  logic          vs_samp, bad_acc;
  logic          line_good_c, frame_start_c, frame_good_c;

  assign hs_act_c  = (hs_q == SYNC_ACTIVE);
  assign vs_act_c  = (vs_q == SYNC_ACTIVE);
  assign hs_edge_c = hs_act_c & ~hs_act_d;
  // h_run already holds the incremented count, so the edge cycle reads as 0
  assign hcnt_c        = hs_edge_c ? '0 : h_run;
  assign line_good_c   = (h_run == CW'(H_TOTAL));
  assign frame_start_c = hs_edge_c & vs_act_c & ~vs_samp;
  assign frame_good_c  = ~bad_acc & line_good_c & (vcnt == CW'(V_TOTAL - 1));

  // line/frame counters
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      h_run   <= '0;
      vcnt    <= '0;
      vs_samp <= 1'b0;
      bad_acc <= 1'b0;
    end else begin
      h_run <= (hcnt_c == CW'(CNT_MAX)) ? hcnt_c : hcnt_c + CW'(1);
      if (hs_edge_c) begin
        vs_samp <= vs_act_c;
        if (frame_start_c) begin
          vcnt    <= '0;
          bad_acc <= 1'b0;
        end else begin
          vcnt    <= (vcnt == CW'(CNT_MAX)) ? vcnt : vcnt + CW'(1);
          bad_acc <= bad_acc | ~line_good_c;
        end
      end
    end
  end

  logic          vis_c, red_c, hit_c;
  logic [CW-1:0] x_c, y_c;

  assign vis_c = (hcnt_c >= CW'(X0)) && (hcnt_c < CW'(X0 + H_VISIBLE)) &&
                 (vcnt >= CW'(Y0)) && (vcnt < CW'(Y0 + V_VISIBLE));
  assign red_c = (r_q >= 4'd8) && (g_q < 4'd8) && (b_q < 4'd8);
  assign hit_c = vis_c & red_c;
  assign x_c   = hcnt_c - CW'(X0);
  assign y_c   = vcnt - CW'(Y0);

  logic [CW-1:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic [CW-1:0] acc_xmin_nx, acc_xmax_nx, acc_ymin_nx, acc_ymax_nx;
  logic          acc_found, acc_found_nx;
`ifdef VGA_FRAME_DECODER_PIXCOUNT_EN
  localparam int unsigned PIX_MAX = 307200;
  logic [18:0]   acc_cnt, acc_cnt_nx;
`endif

  // running box: restart at frame start, then fold in the current pixel
  always_comb begin
    acc_xmin_nx  = acc_xmin;
    acc_xmax_nx  = acc_xmax;
    acc_ymin_nx  = acc_ymin;
    acc_ymax_nx  = acc_ymax;
    acc_found_nx = acc_found;
`ifdef VGA_FRAME_DECODER_PIXCOUNT_EN
    acc_cnt_nx   = acc_cnt;
`endif
    if (frame_start_c) begin
      acc_xmin_nx  = CW'(CNT_MAX);
      acc_xmax_nx  = '0;
      acc_ymin_nx  = CW'(CNT_MAX);
      acc_ymax_nx  = '0;
      acc_found_nx = 1'b0;
`ifdef VGA_FRAME_DECODER_PIXCOUNT_EN
      acc_cnt_nx   = '0;
`endif
    end
    if (hit_c) begin
      if (x_c < acc_xmin_nx) acc_xmin_nx = x_c;
      if (x_c > acc_xmax_nx) acc_xmax_nx = x_c;
      if (y_c < acc_ymin_nx) acc_ymin_nx = y_c;
      if (y_c > acc_ymax_nx) acc_ymax_nx = y_c;
      acc_found_nx = 1'b1;
`ifdef VGA_FRAME_DECODER_PIXCOUNT_EN
      if (acc_cnt_nx != 19'(PIX_MAX)) acc_cnt_nx = acc_cnt_nx + 19'(1);
`endif
    end
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      acc_xmin  <= CW'(CNT_MAX);
      acc_xmax  <= '0;
      acc_ymin  <= CW'(CNT_MAX);
      acc_ymax  <= '0;
      acc_found <= 1'b0;
`ifdef VGA_FRAME_DECODER_PIXCOUNT_EN
      acc_cnt   <= '0;
`endif
    end else begin
      acc_xmin  <= acc_xmin_nx;
      acc_xmax  <= acc_xmax_nx;
      acc_ymin  <= acc_ymin_nx;
      acc_ymax  <= acc_ymax_nx;
      acc_found <= acc_found_nx;
`ifdef VGA_FRAME_DECODER_PIXCOUNT_EN
      acc_cnt   <= acc_cnt_nx;
`endif
    end
  end

  state_t        state, state_nx;
  logic [LW-1:0] good_cnt, good_cnt_nx;
  logic          publish_c;

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state    <= ST_SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_nx;
      good_cnt <= good_cnt_nx;
    end
  end

  // lock FSM: only acts on frame starts
  always_comb begin
    state_nx    = state;
    good_cnt_nx = good_cnt;
    publish_c   = 1'b0;
    if (frame_start_c) begin
      case (state)
        ST_SEARCH: begin
          state_nx    = ST_VERIFY;
          good_cnt_nx = '0;
        end
        ST_VERIFY: begin
          if (!frame_good_c) begin
            good_cnt_nx = '0;
          end else if (good_cnt == LW'(LOCK_FRAMES - 1)) begin
            state_nx    = ST_LOCKED;
            good_cnt_nx = '0;
          end else begin
            good_cnt_nx = good_cnt + LW'(1);
          end
        end
        ST_LOCKED: begin
          if (frame_good_c) publish_c = 1'b1;
          else              state_nx  = ST_SEARCH;
        end
        default: state_nx = ST_SEARCH;
      endcase
    end
  end

  // published results; the accumulators still hold the completed frame here
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      locked     <= 1'b0;
      frame_done <= 1'b0;
      obj_found  <= 1'b0;
      obj_xmin   <= '0;
      obj_xmax   <= '0;
      obj_ymin   <= '0;
      obj_ymax   <= '0;
`ifdef VGA_FRAME_DECODER_PIXCOUNT_EN
      obj_count  <= '0;
`endif
    end else begin
      locked     <= (state_nx == ST_LOCKED);
      frame_done <= publish_c;
      if (publish_c) begin
        obj_found <= acc_found;
        obj_xmin  <= acc_found ? acc_xmin : '0;
        obj_xmax  <= acc_found ? acc_xmax : '0;
        obj_ymin  <= acc_found ? acc_ymin : '0;
        obj_ymax  <= acc_found ? acc_ymax : '0;
`ifdef VGA_FRAME_DECODER_PIXCOUNT_EN
        obj_count <= acc_cnt;
`endif
      end
    end
  end

endmodule
